vend_fsm: RTL and testbench
===========================

// Module: vend_fsm
// PURPOSE
//   Beverage vending controller: accumulates inserted coin value into a credit register,
//   dispenses one of two beverages on button request when credit covers the price,
//   and returns the remaining credit as change once it falls below the cheapest price.
//   Sits between the coin acceptor / keypad front-end and the dispenser / change hopper.
// PARAMETERS
//   PRICE_A       30  price of beverage code 2'b01 (credit units)
//   PRICE_B       50  price of beverage code 2'b11 (credit units)
//   BEV_DELAY     1   cycles beverage_out is held (dispense time), >=1
//   CHANGE_DELAY  2   cycles change_out is held (hopper time), >=1
// PORTS
//   clk           in   1   clock, rising-edge
//   rst           in   1   synchronous, active-high reset
//   coin_in       in   16  coin value this cycle; 0 = no coin
//   button_in     in   2   2'b00 none, 2'b01 bev A, 2'b11 bev B, 2'b10 refund/reserved
//   change_out    out  16  change amount being returned; 0 otherwise
//   beverage_out  out  2   code of beverage being dispensed; 2'b00 otherwise
// BEHAVIOUR
//   - All state and outputs registered; all inputs sampled on rising clk.
//   - Reset: state=IDLE, credit=0, cnt=0, change_out=0, beverage_out=2'b00.
//   - Internal credit register: 16 bit, name `credit`; adds saturate at 16'hFFFF.
//   - MIN_PRICE = min(PRICE_A, PRICE_B).
//   - IDLE:
//       coin_in!=0 -> credit += coin_in (same cycle as any button).
//       button 01 and credit>=PRICE_A -> credit -= PRICE_A, DISPENSE, beverage_out=01.
//       button 11 and credit>=PRICE_B -> credit -= PRICE_B, DISPENSE, beverage_out=11.
//       button pressed with insufficient credit -> ignored, stay IDLE.
//       button 10 -> see CONFIGURATION; without feature ignored.
//       Price check uses credit before the same-cycle coin add.
//   - DISPENSE (BEV_DELAY cycles): beverage_out held; coin_in and button_in ignored
//     (coins inserted here are lost, not credited). On exit: if credit<MIN_PRICE and
//     credit>0 -> CHANGE; else IDLE with beverage_out=00.
//   - CHANGE (CHANGE_DELAY cycles): change_out=credit, beverage_out=00, inputs ignored.
//     On exit credit=0, change_out=0, -> IDLE.
//   - A button held across several cycles: only accepted in IDLE; re-accepted after
//     returning to IDLE if still held (level-sensitive, no edge detect).
//   - Reset mid-operation aborts delivery/change: everything to reset values next cycle.
// CONFIGURATION
//   REFUND_BUTTON_EN defined: in IDLE, button 10 with credit>0 -> CHANGE returning full
//     credit (change_out=credit for CHANGE_DELAY cycles, then credit=0); credit=0 -> ignored.
//   Not defined: button 10 always ignored, credit unchanged.
// TESTING
//   rst 1 cycle; coin 200 then 20 -> credit=220, outputs 00/0.
//   button 11 -> beverage_out=11 for 1 cycle, credit=170; three more 11 presses ->
//     credit 120, 70, 20; after last: change_out=20 for 2 cycles, then credit=0.
//   credit 80, button 01 twice -> credit 50, 20, then change_out=20; coin 10 during
//     dispense -> not credited.
//   credit 20, button 01 -> no beverage, credit stays 20; button 10 (no macro) ignored.
//   REFUND_BUTTON_EN: coin 100, button 10 -> change_out=100 for 2 cycles, credit=0.
//   rst asserted during CHANGE -> next cycle change_out=0, credit=0, IDLE.

Source files
------------

// File: rtl/vend_fsm.sv
// vend_fsm: two-beverage vending controller.
// Coin values are accumulated into a saturating 16-bit credit register.
// A beverage is dispensed when the button is pressed and the credit covers its price.
// Any leftover credit below the cheapest price is returned through the change hopper.
// Optional feature macro: REFUND_BUTTON_EN. When it is defined, button 2'b10 returns
// the full credit as change.
module vend_fsm #(
  parameter int PRICE_A      = 30,
  parameter int PRICE_B      = 50,
  parameter int BEV_DELAY    = 1,
  parameter int CHANGE_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] coin_in,
  input  logic [1:0]  button_in,
  output logic [15:0] change_out,
  output logic [1:0]  beverage_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPENSE = 2'b01,
    CHANGE   = 2'b10
  } state_t;

  localparam int          MIN_PRICE   = (PRICE_A < PRICE_B) ? PRICE_A : PRICE_B;
  localparam logic [15:0] PRICE_A_V   = 16'(PRICE_A);
  localparam logic [15:0] PRICE_B_V   = 16'(PRICE_B);
  localparam logic [15:0] MIN_PRICE_V = 16'(MIN_PRICE);
  localparam logic [15:0] BEV_LAST    = 16'(BEV_DELAY - 1);
  localparam logic [15:0] CHANGE_LAST = 16'(CHANGE_DELAY - 1);

  localparam logic [1:0] BTN_A      = 2'b01;
  localparam logic [1:0] BTN_B      = 2'b11;
  localparam logic [1:0] BTN_REFUND = 2'b10;
  localparam logic [1:0] BEV_NONE   = 2'b00;

  state_t      state_r;
  logic [15:0] credit;
  logic [15:0] cnt_r;

  // Adds two credit values, clamping at the top of the 16-bit range.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Vending FSM: credit bookkeeping, dispense timing and change return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      credit       <= 16'd0;
      cnt_r        <= 16'd0;
      change_out   <= 16'd0;
      beverage_out <= BEV_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          // The price check uses the credit from before this cycle's coin.
          if (button_in == BTN_A && credit >= PRICE_A_V) begin
            credit       <= sat_add(credit - PRICE_A_V, coin_in);
            beverage_out <= BTN_A;
            cnt_r        <= 16'd0;
            state_r      <= DISPENSE;
          end else if (button_in == BTN_B && credit >= PRICE_B_V) begin
            credit       <= sat_add(credit - PRICE_B_V, coin_in);
            beverage_out <= BTN_B;
            cnt_r        <= 16'd0;
            state_r      <= DISPENSE;
`ifdef REFUND_BUTTON_EN
          end else if (button_in == BTN_REFUND && credit != 16'd0) begin
            // A coin arriving in the same cycle is refunded together with the credit.
            credit     <= sat_add(credit, coin_in);
            change_out <= sat_add(credit, coin_in);
            cnt_r      <= 16'd0;
            state_r    <= CHANGE;
`endif
          end else begin
            credit <= sat_add(credit, coin_in);
          end
        end
        DISPENSE: begin
          // Coins arriving during dispense are not credited.
          if (cnt_r == BEV_LAST) begin
            beverage_out <= BEV_NONE;
            cnt_r        <= 16'd0;
            if (credit < MIN_PRICE_V && credit != 16'd0) begin
              change_out <= credit;
              state_r    <= CHANGE;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        CHANGE: begin
          if (cnt_r == CHANGE_LAST) begin
            credit     <= 16'd0;
            change_out <= 16'd0;
            cnt_r      <= 16'd0;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r      <= IDLE;
          credit       <= 16'd0;
          cnt_r        <= 16'd0;
          change_out   <= 16'd0;
          beverage_out <= BEV_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm.sv
// tb_vend_fsm: directed, table-driven bench for vend_fsm with default parameters.
// Each table row holds the inputs for one clock edge and the values expected after
// that edge. Hand-written sequences cover saturation and reset during change.
module tb_vend_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] coin_in;
  logic [1:0]  button_in;
  logic [15:0] change_out;
  logic [1:0]  beverage_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] coin;
    logic [1:0]  button;
    logic [15:0] exp_change;
    logic [1:0]  exp_bev;
    logic [15:0] exp_credit;
  } vec_t;

  vec_t vecs[$];

  vend_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .coin_in      (coin_in),
    .button_in    (button_in),
    .change_out   (change_out),
    .beverage_out (beverage_out)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  task automatic add(input logic [15:0] c, input logic [1:0] b, input logic [15:0] ch,
                     input logic [1:0] bv, input logic [15:0] cr);
    vec_t v;
    v.coin = c; v.button = b; v.exp_change = ch; v.exp_bev = bv; v.exp_credit = cr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%04h), expected %0d (0x%04h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ch, input logic [1:0] bv,
                         input logic [15:0] cr);
    chk({tag, " change_out"}, change_out, ch);
    chk({tag, " beverage_out"}, {14'd0, beverage_out}, {14'd0, bv});
    chk({tag, " credit"}, dut.credit, cr);
  endtask

  initial begin
    // Purchase of B four times, ending in change.
    add(16'd200, 2'b00, 16'd0,  2'b00, 16'd200);
    add(16'd20,  2'b00, 16'd0,  2'b00, 16'd220);
    add(16'd0,   2'b11, 16'd0,  2'b11, 16'd170);
    add(16'd0,   2'b00, 16'd0,  2'b00, 16'd170);
    add(16'd0,   2'b11, 16'd0,  2'b11, 16'd120);
    add(16'd0,   2'b00, 16'd0,  2'b00, 16'd120);
    add(16'd0,   2'b11, 16'd0,  2'b11, 16'd70);
    add(16'd0,   2'b00, 16'd0,  2'b00, 16'd70);
    add(16'd0,   2'b11, 16'd0,  2'b11, 16'd20);
    add(16'd0,   2'b00, 16'd20, 2'b00, 16'd20);
    add(16'd0,   2'b00, 16'd20, 2'b00, 16'd20);
    add(16'd0,   2'b00, 16'd0,  2'b00, 16'd0);
    // Credit 80, two A purchases, coin lost during dispense.
    add(16'd80,  2'b00, 16'd0,  2'b00, 16'd80);
    add(16'd0,   2'b01, 16'd0,  2'b01, 16'd50);
    add(16'd10,  2'b00, 16'd0,  2'b00, 16'd50);
    add(16'd0,   2'b01, 16'd0,  2'b01, 16'd20);
    add(16'd0,   2'b00, 16'd20, 2'b00, 16'd20);
    add(16'd0,   2'b00, 16'd20, 2'b00, 16'd20);
    add(16'd0,   2'b00, 16'd0,  2'b00, 16'd0);
    // Button A held: re-accepted each time the FSM is back in IDLE.
    add(16'd100, 2'b00, 16'd0,  2'b00, 16'd100);
    add(16'd0,   2'b01, 16'd0,  2'b01, 16'd70);
    add(16'd0,   2'b01, 16'd0,  2'b00, 16'd70);
    add(16'd0,   2'b01, 16'd0,  2'b01, 16'd40);
    add(16'd0,   2'b01, 16'd0,  2'b00, 16'd40);
    add(16'd0,   2'b01, 16'd0,  2'b01, 16'd10);
    add(16'd0,   2'b01, 16'd10, 2'b00, 16'd10);
    add(16'd0,   2'b01, 16'd10, 2'b00, 16'd10);
    add(16'd0,   2'b01, 16'd0,  2'b00, 16'd0);
    add(16'd0,   2'b01, 16'd0,  2'b00, 16'd0);
    // Insufficient credit; the price check ignores the same-cycle coin.
    add(16'd20,  2'b00, 16'd0,  2'b00, 16'd20);
    add(16'd0,   2'b01, 16'd0,  2'b00, 16'd20);
    add(16'd0,   2'b11, 16'd0,  2'b00, 16'd20);
    add(16'd10,  2'b01, 16'd0,  2'b00, 16'd30);
    // Exact price: credit 0 after dispense goes straight back to IDLE.
    add(16'd0,   2'b01, 16'd0,  2'b01, 16'd0);
    add(16'd0,   2'b00, 16'd0,  2'b00, 16'd0);
    // Refund button.
    add(16'd100, 2'b00, 16'd0,  2'b00, 16'd100);
`ifdef REFUND_BUTTON_EN
    add(16'd0,   2'b10, 16'd100, 2'b00, 16'd100);
    add(16'd0,   2'b00, 16'd100, 2'b00, 16'd100);
    add(16'd0,   2'b00, 16'd0,   2'b00, 16'd0);
`else
    add(16'd0,   2'b10, 16'd0,  2'b00, 16'd100);
    add(16'd0,   2'b10, 16'd0,  2'b00, 16'd100);
    add(16'd0,   2'b00, 16'd0,  2'b00, 16'd100);
`endif

    rst = 1'b1; coin_in = 16'd0; button_in = 2'b00;
    step();
    chk_all("reset", 16'd0, 2'b00, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      coin_in   = vecs[i].coin;
      button_in = vecs[i].button;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_change, vecs[i].exp_bev, vecs[i].exp_credit);
    end

    // Saturation of the credit register, then a purchase from the saturated value.
    rst = 1'b1; coin_in = 16'd0; button_in = 2'b00;
    step();
    rst = 1'b0; coin_in = 16'hFFF0;
    step();
    chk("sat first", dut.credit, 16'hFFF0);
    coin_in = 16'h0100;
    step();
    chk("sat clamp", dut.credit, 16'hFFFF);
    coin_in = 16'd0; button_in = 2'b11;
    step();
    chk_all("sat buy", 16'd0, 2'b11, 16'hFFCD);
    button_in = 2'b00;
    step();
    chk_all("sat idle", 16'd0, 2'b00, 16'hFFCD);

    // Reset asserted while change is being returned.
    rst = 1'b1;
    step();
    rst = 1'b0; coin_in = 16'd40;
    step();
    coin_in = 16'd0; button_in = 2'b01;
    step();
    chk_all("rc buy", 16'd0, 2'b01, 16'd10);
    button_in = 2'b00;
    step();
    chk_all("rc change", 16'd10, 2'b00, 16'd10);
    rst = 1'b1;
    step();
    chk_all("rc reset", 16'd0, 2'b00, 16'd0);
    rst = 1'b0;
    step();
    chk_all("rc idle", 16'd0, 2'b00, 16'd0);
    coin_in = 16'd30;
    step();
    coin_in = 16'd0; button_in = 2'b01;
    step();
    chk_all("rc rebuy", 16'd0, 2'b01, 16'd0);
    button_in = 2'b00;
    step();
    chk_all("rc done", 16'd0, 2'b00, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
